// File: rtl/iter_mdu_pkg.sv
// rtl/iter_mdu_pkg.sv - shared op/state types and helpers for the iterative mul/div unit
package iter_mdu_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'd0,
    MULTU = 2'd1,
    DIV   = 2'd2,
    DIVU  = 2'd3
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  function automatic logic op_is_div(mdu_op_t op);
    return (op == DIV) || (op == DIVU);
  endfunction

  function automatic logic op_is_signed(mdu_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// rtl/mdu_signfix.sv - combinational two's-complement negate when neg is set
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Negation is ~x + 1; the most-negative value maps onto itself, which the
  // unsigned datapath relies on for abs().
  always_comb begin
    dout = neg ? ((~din) + ONE) : din;
  end

endmodule

// File: rtl/iter_mdu.sv
// rtl/iter_mdu.sv - radix-2 iterative multiply/divide unit with fixed WIDTH+1 latency
module iter_mdu
  import iter_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_t       state_q, state_d;
  mdu_op_t          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // hi: product upper half / partial remainder; lo: multiplier / dividend-quotient
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // |a| for multiply (the addend), |b| for divide (the divisor)
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;

  mdu_op_t          req_op_e;
  logic             req_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;

  logic [WIDTH-1:0]   mul_add;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand sign decode for the incoming request.
  always_comb begin
    req_op_e   = mdu_op_t'(req_op);
    req_signed = op_is_signed(req_op_e);
    a_neg      = req_signed & src_a[WIDTH-1];
    b_neg      = req_signed & src_b[WIDTH-1];
  end

  mdu_signfix #(.W(WIDTH)) u_abs_a (.din(src_a), .neg(a_neg), .dout(abs_a));
  mdu_signfix #(.W(WIDTH)) u_abs_b (.din(src_b), .neg(b_neg), .dout(abs_b));

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    mul_add   = lo_q[0] ? opnd_q : '0;
    mul_sum   = {1'b0, hi_q} + {1'b0, mul_add};
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_is_div(op_q)) begin
      if (!div_diff[WIDTH]) begin
        step_hi = div_diff[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = div_shift[WIDTH-1:0];
        step_lo = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  mdu_signfix #(.W(2*WIDTH)) u_fix_prod (.din({step_hi, step_lo}), .neg(neg_lo_q), .dout(prod_fix));
  mdu_signfix #(.W(WIDTH))   u_fix_quo  (.din(step_lo), .neg(neg_lo_q), .dout(quo_fix));
  mdu_signfix #(.W(WIDTH))   u_fix_rem  (.din(step_hi), .neg(neg_hi_q), .dout(rem_fix));

  // Next-state and datapath control; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          state_d = CALC;
          op_d    = req_op_e;
          cnt_d   = '0;
          hi_d    = '0;
          if (op_is_div(req_op_e)) begin
            lo_d     = abs_a;
            opnd_d   = abs_b;
            // A zero divisor keeps the all-ones quotient unsigned.
            neg_lo_d = (a_neg ^ b_neg) & (src_b != '0);
            neg_hi_d = a_neg;
          end else begin
            lo_d     = abs_b;
            opnd_d   = abs_a;
            neg_lo_d = a_neg ^ b_neg;
            neg_hi_d = 1'b0;
          end
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (op_is_div(op_q)) begin
            res_hi_d = rem_fix;
            res_lo_d = quo_fix;
          end else begin
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      res_hi_d = '0;
      res_lo_d = '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= MULT;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    req_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
    res_hi    = res_hi_q;
    res_lo    = res_lo_q;
  end

endmodule

// File: tb/tb_iter_mdu.sv
// tb/tb_iter_mdu.sv - scoreboard bench for iter_mdu
module tb_iter_mdu;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_hi, res_lo;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  iter_mdu #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .src_a(src_a), .src_b(src_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_hi(res_hi), .res_lo(res_lo), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model built on the language operators.
  function automatic logic [63:0] ref_mdu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'd0: begin p = sa * sb; return p; end
      2'd1: begin up = ua * ub; return up; end
      2'd2: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb; r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (resetn && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got %h expected none", {res_hi, res_lo});
      end else begin
        mon_exp = exp_q.pop_front();
        chk("result", {res_hi, res_lo}, mon_exp);
      end
    end
  end

  // Called at a negedge; presents one request and returns at the next negedge (cycle 1).
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk("ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    src_a     = a;
    src_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int lat = 1;
    while (!res_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd33);
    chk({name, "_ready_in_done"}, 64'(req_ready), 64'd0);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    exp_q.push_back(exp);
    issue(op, a, b);
    wait_result(name);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("reset_busy_valid", {62'b0, busy, res_valid}, 64'd0);
    chk("reset_result", {res_hi, res_lo}, 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    resetn = 1'b1;
    @(negedge clk);

    run_op("mult_neg1_7",  2'd0, 32'hFFFFFFFF, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFF9});
    run_op("divu_100_7",   2'd3, 32'd100,      32'd7, {32'd2, 32'd14});
    run_op("div_m7_2",     2'd2, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div_ovf",      2'd2, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000});
    run_op("divu_by0",     2'd3, 32'd5,        32'd0, {32'd5, 32'hFFFFFFFF});
    run_op("div_m5_by0",   2'd2, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF});
    run_op("mult_mneg_sq", 2'd0, 32'h80000000, 32'h80000000, {32'h40000000, 32'h0});
    run_op("multu_max_sq", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});

    // Back-pressure: result held for 10 cycles.
    res_ready = 1'b0;
    exp_q.push_back({32'd2, 32'd14});
    issue(2'd3, 32'd100, 32'd7);
    wait_result("hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", {res_hi, res_lo}, {32'd2, 32'd14});
    end
    @(posedge clk);
    #2 res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_release_ready", {62'b0, req_ready, busy}, 64'd2);

    // Flush mid-CALC, then flush racing a request.
    issue(2'd0, 32'h12345678, 32'h9);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {62'b0, busy, res_valid}, 64'd0);
    req_valid = 1'b1; req_op = 2'd1; src_a = 32'd3; src_b = 32'd5; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_beats_req", 64'(busy), 64'd0);
    run_op("multu_3_5", 2'd1, 32'd3, 32'd5, {32'd0, 32'd15});

    // Asynchronous reset mid-CALC; outputs still hold the previous result beforehand.
    issue(2'd3, 32'hDEADBEEF, 32'd7);
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_flags", {62'b0, busy, res_valid}, 64'd0);
    chk("async_reset_data", {res_hi, res_lo}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run_op("divu_9_3", 2'd3, 32'd9, 32'd3, {32'd0, 32'd3});

    // Random operands biased toward corner values, all four ops.
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      run_op("rand", rop, ra, rb, ref_mdu(rop, ra, rb));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iter_mdu.md
ITER_MDU -- requirements
Module: iter_mdu

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the operand width (even, >= 4).
REQ-002 The module SHALL have parameter CNT_W, default $clog2(WIDTH)+1, the iteration counter width.
REQ-003 The module SHALL have port clk  input  1  the single clock, with all state on its rising edge.
REQ-004 The module SHALL have port resetn  input  1  the reset, asynchronous and active-low.
REQ-005 The module SHALL have port flush  input  1  the pipeline cancel, which aborts any operation.
REQ-006 The module SHALL have port req_valid  input  1  the operation request.
REQ-007 The module SHALL have port req_ready  output  1  high only in IDLE.
REQ-008 The module SHALL have port req_op  input  2  the operation code: MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-009 The module SHALL have ports src_a and src_b  input  WIDTH  carrying the multiplicand/dividend and the multiplier/divisor.
REQ-010 The module SHALL have port res_valid  output  1  the result-available flag.
REQ-011 The module SHALL have port res_ready  input  1  the consumer-accepts flag.
REQ-012 The module SHALL have ports res_hi and res_lo  output  WIDTH  carrying the product high/low, or the remainder/quotient.
REQ-013 The module SHALL have port busy  output  1  high in CALC or DONE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 On req_valid&&req_ready&&!flush in IDLE, the block SHALL latch the op, store the operands as absolute values when signed, record the result signs, clear the counter and go to CALC.
REQ-016 In CALC, each cycle SHALL perform one radix-2 step: shift-add for multiply, restoring subtract-shift on a WIDTH+1-bit partial remainder for divide.
REQ-017 After exactly WIDTH CALC cycles (counter == WIDTH-1), the block SHALL go to DONE with the sign-corrected result registered.
REQ-018 Total latency from accept to the first res_valid SHALL be WIDTH+1 cycles, independent of operand values.
REQ-019 Signed product sign SHALL be a[MSB]^b[MSB]; quotient sign SHALL be a^b; remainder sign SHALL be a[MSB] (dividend).
REQ-020 Divide by zero SHALL return res_lo = all ones and res_hi = src_a unchanged, with the same latency and no exception.
REQ-021 Signed most-negative / -1 SHALL return res_lo = most-negative and res_hi = 0.
REQ-022 In DONE, res_valid SHALL be 1 and res_hi/res_lo SHALL be held stable until res_valid&&res_ready, after which the block returns to IDLE on the next edge.
REQ-023 req_ready SHALL be 0 in the DONE cycle even when res_ready is high; a new request is accepted no earlier than the following IDLE cycle.
REQ-024 flush SHALL force IDLE on the next edge from any state, discard any pending result and clear res_valid.
REQ-025 flush SHALL win over a same-cycle req_valid, so the request is not accepted.
REQ-026 The outputs SHALL not depend combinationally on src_a, src_b or req_op.

Reset
REQ-027 While resetn is low, the block SHALL hold state IDLE, counter 0, res_valid 0, res_hi/res_lo 0 and busy 0.
REQ-028 Reset asserted mid-CALC SHALL abort the operation immediately, with no result produced.

Structure
REQ-029 A shared package SHALL hold the mdu_op_t enum (MULT, MULTU, DIV, DIVU) and the mdu_state_t enum (IDLE, CALC, DONE).
REQ-030 Sign handling SHALL be a sub-module mdu_signfix, a purely combinational negate-if-flag unit, instantiated for operand abs and for result correction.
REQ-031 There SHALL be no multiplier primitive and no `/` or `%` operators.

Verification (WIDTH=32)
REQ-032 Scenario: MULT with a=0xFFFFFFFF (-1) and b=7 -> res_valid on cycle 33 after accept, hi=0xFFFFFFFF, lo=0xFFFFFFF9.
REQ-033 Scenario: DIVU with a=100 and b=7 -> lo=14, hi=2; DIV with a=-7 and b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 Scenario: DIV with a=0x80000000 and b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU with a=5 and b=0 -> lo=0xFFFFFFFF, hi=5.
REQ-035 Scenario: hold res_ready=0 for 10 cycles in DONE -> res_valid stays 1 and the outputs are stable; assert res_ready -> IDLE next cycle, req_ready=1.
REQ-036 Scenario: flush at CALC cycle 10, then a new MULTU with a=3 and b=5 -> no result from the first operation; second gives hi=0, lo=15.
REQ-037 Scenario: resetn low mid-CALC -> all outputs 0 asynchronously; after release, a new DIVU with a=9 and b=3 gives lo=3, hi=0.
REQ-038 The bench SHALL use a random-operand scoreboard against a reference model for all four ops, including operands 0, 1, -1 and most-negative.
